// File: rtl/moving_interpolator_pkg.sv
// Shared types and constants for the moving interpolator.
// Feature macro LINEAR_INTERP_EN selects linear vs zero-order-hold output.
package moving_interpolator_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int DELTA_W           = 17;
  localparam int CTRL_ENABLE       = 0;
  localparam int CTRL_UNDERRUN_CLR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/moving_interpolator_lerp_core.sv
// Registered output datapath: prev + (delta*k >>> L) in RUN.
// LINEAR_INTERP_EN defined: multiplier; undefined: zero-order hold.
module interp_lerp_core
  import moving_interpolator_pkg::*;
#(
  parameter int L = 10
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       clr,
  input  state_t                     mode,
  input  logic signed [SAMPLE_W-1:0] prev,
  input  logic signed [SAMPLE_W-1:0] cur,
  input  logic signed [DELTA_W-1:0]  delta,
  input  logic        [L-1:0]        k,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       out_valid
);

  logic signed [SAMPLE_W-1:0] run_val;

`ifdef LINEAR_INTERP_EN
  localparam int PW = DELTA_W + L;

  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic                 unused_hi;

  assign d_ext   = {{L{delta[DELTA_W-1]}}, delta};
  assign k_ext   = {{DELTA_W{1'b0}}, k};
  assign prod    = d_ext * k_ext;
  assign shifted = prod >>> L;
  // result lies between prev and cur, so low bits suffice
  assign run_val   = prev + shifted[SAMPLE_W-1:0];
  assign unused_hi = ^shifted[PW-1:SAMPLE_W];
`else
  logic unused_lerp;

  assign unused_lerp = ^{delta, k};
  assign run_val     = prev;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (mode)
        PRIME: begin
          out       <= cur;
          out_valid <= 1'b1;
        end
        RUN: begin
          out       <= run_val;
          out_valid <= 1'b1;
        end
        default: begin
          out       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/moving_interpolator.sv
// Rate-expanding interpolator: one input per 2^L clocks, one output per clock.
// LINEAR_INTERP_EN defined: linear; undefined: zero-order hold.
module moving_interpolator
  import moving_interpolator_pkg::*;
#(
  parameter int G_INTERP_LENGTH_LOG = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [SAMPLE_W-1:0] InputA,
  input  logic                InValid,
  output logic                InReady,
  input  logic [15:0]         Control0,
  output logic [SAMPLE_W-1:0] OutputA,
  output logic                OutValid,
  output logic                Underrun
);

  localparam int L = G_INTERP_LENGTH_LOG;
  localparam logic [L-1:0] K_MAX = '1;

  state_t state_q, state_d;
  logic [L-1:0] k_q, k_d;
  logic signed [SAMPLE_W-1:0] prev_q, prev_d;
  logic signed [SAMPLE_W-1:0] cur_q, cur_d;
  logic signed [DELTA_W-1:0] delta_q, delta_d;
  logic under_q, under_d, under_set;
  logic enable, xfer, unused_ctrl;

  assign enable      = Control0[CTRL_ENABLE];
  assign unused_ctrl = ^Control0[15:2];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    delta_d   = delta_q;
    under_set = 1'b0;
    InReady   = Reset & enable &
                ((state_q == IDLE) | (state_q == PRIME) |
                 ((state_q == RUN) & (k_q == K_MAX)));
    xfer      = InValid & InReady;
    if (!enable) begin
      state_d = IDLE;
      k_d     = '0;
      prev_d  = '0;
      cur_d   = '0;
      delta_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            cur_d   = InputA;
            state_d = PRIME;
          end
        end
        PRIME, RUN: begin
          if (state_q == RUN)
            k_d = k_q + 1'b1;
          if (xfer) begin
            prev_d  = cur_q;
            cur_d   = InputA;
            delta_d = {InputA[SAMPLE_W-1], InputA}
                    - {cur_q[SAMPLE_W-1], cur_q};
            k_d     = '0;
            state_d = RUN;
          end else if (state_q == RUN && k_q == K_MAX) begin
            under_set = 1'b1;
            state_d   = PRIME;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    under_d = under_set | (under_q & ~Control0[CTRL_UNDERRUN_CLR]);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      delta_q <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      delta_q <= delta_d;
      under_q <= under_d;
    end
  end

  assign Underrun = under_q;

  interp_lerp_core #(
    .L(L)
  ) u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (~enable),
    .mode     (state_q),
    .prev     (prev_q),
    .cur      (cur_q),
    .delta    (delta_q),
    .k        (k_q),
    .out      (OutputA),
    .out_valid(OutValid)
  );

endmodule
